// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : counter_pkg
//  Purpose : Shared operation encoding and input decoding for the up/down
//            modulo counter (counter_updown_mod and counter_next_val).
//  Rev     : 1.0  initial release
// ============================================================================
package counter_pkg;

  // One operation is applied per qualified clock edge
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } cnt_op_t;

  // Priority decode: load wins; inc and dec together cancel to a hold
  function automatic cnt_op_t decode_op(input logic i_load,
                                        input logic i_inc,
                                        input logic i_dec);
    cnt_op_t op;
    op = OP_HOLD;
    if (i_load) begin
      op = OP_LOAD;
    end else if (i_inc && !i_dec) begin
      op = OP_INC;
    end else if (i_dec && !i_inc) begin
      op = OP_DEC;
    end
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_next_val.sv
`default_nettype none
// ============================================================================
//  Module  : counter_next_val
//  Purpose : Combinational next-count and boundary-event computation.
//            Handles load clamping, modulo wrap and (with COUNTER_SAT_EN
//            defined) saturation at the range limits.
//  Config  : COUNTER_SAT_EN - saturate instead of wrapping at 0 / MODULO-1
//  Rev     : 1.0  initial release
// ============================================================================
module counter_next_val
  import counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic [WIDTH-1:0] cnt,
  input  cnt_op_t          op,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] nxt,
  output logic             evt
);

  // Terminal value in both widths: the extended form keeps comparisons
  // exact even when MODULO == 2**WIDTH.
  localparam logic [WIDTH:0]   C_MAX_W = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH-1:0] C_MAX_N = WIDTH'(MODULO - 1);

  logic [WIDTH:0] w_cnt_ext;
  logic [WIDTH:0] w_ld_ext;
  logic           w_at_max;
  logic           w_at_min;

  assign w_cnt_ext = {1'b0, cnt};
  assign w_ld_ext  = {1'b0, load_val};
  assign w_at_max  = (w_cnt_ext >= C_MAX_W);
  assign w_at_min  = (w_cnt_ext == '0);

  // Next value selection; increments/decrements are only taken away from
  // the limits, so they never overflow WIDTH bits.
  always_comb begin
    nxt = cnt;
    evt = 1'b0;
    case (op)
      OP_LOAD: begin
        nxt = (w_ld_ext > C_MAX_W) ? C_MAX_N : load_val;
      end
      OP_INC: begin
        if (w_at_max) begin
          evt = 1'b1;
`ifdef COUNTER_SAT_EN
          nxt = C_MAX_N;
`else
          nxt = '0;
`endif
        end else begin
          nxt = cnt + WIDTH'(1);
        end
      end
      OP_DEC: begin
        if (w_at_min) begin
          evt = 1'b1;
`ifdef COUNTER_SAT_EN
          nxt = '0;
`else
          nxt = C_MAX_N;
`endif
        end else begin
          nxt = cnt - WIDTH'(1);
        end
      end
      default: begin
        nxt = cnt;
        evt = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/counter_updown_mod.sv
`default_nettype none
// ============================================================================
//  Module  : counter_updown_mod
//  Purpose : Parametrised up/down modulo counter with parallel load,
//            registered wrap pulse and sticky overflow flag. co/bo are
//            terminal-count outputs for ripple cascading.
//  Config  : COUNTER_SAT_EN - saturating mode (events still reported)
//  Rev     : 1.0  initial release
// ============================================================================
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16,
  parameter int INIT   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             inc_cnt,
  input  logic             dec_cnt,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cnt_out,
  output logic             co,
  output logic             bo,
  output logic             wrap_p,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] C_INIT = WIDTH'(INIT);

  logic [WIDTH-1:0] r_cnt;
  logic             r_wrap;
  logic             r_ovf;
  cnt_op_t          w_op;
  logic [WIDTH-1:0] w_nxt;
  logic             w_evt;

  // clk_en gates every count/load action; a disabled cycle is a hold
  assign w_op = clk_en ? decode_op(load, inc_cnt, dec_cnt) : OP_HOLD;

  counter_next_val #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_next_val (
    .cnt      (r_cnt),
    .op       (w_op),
    .load_val (load_val),
    .nxt      (w_nxt),
    .evt      (w_evt)
  );

  // State update: reset dominates; a boundary event sets ovf ahead of clr_ovf
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= C_INIT;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_cnt  <= w_nxt;
      r_wrap <= w_evt;
      if (w_evt) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign cnt_out = r_cnt;
  assign wrap_p  = r_wrap;
  assign ovf     = r_ovf;
  assign co      = (r_cnt == C_MAX);
  assign bo      = (r_cnt == '0);

endmodule
`default_nettype wire
